// File: rtl/qtree_ctrl_package.sv
// rtl/qtree_ctrl_package.sv - shared state enum, token typedefs and default parameters for the qtree run controller
package qtree_ctrl_package;

    localparam int DEF_NUM_ARGS = 2;
    localparam int DEF_PTR_W    = 16;
    localparam int DEF_RES_W    = 32;
    localparam int DEF_TMO_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_ERROR    = 3'd5
    } run_state_t;

    // Pointer token: {pointer, valid}
    typedef logic [DEF_PTR_W:0] ptr_tok_t;
    // Result token: {result, valid}
    typedef logic [DEF_RES_W:0] res_tok_t;

endpackage

// File: rtl/tok_issue.sv
// rtl/tok_issue.sv - one-shot token latch: raised on load, dropped after its ready is sampled
module tok_issue (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic ready,
    output logic pending
);

    // Token stays up until the consumer takes it; it is only re-armed by the next load
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (load) begin
            pending <= 1'b1;
        end else if (pending && ready) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/qtree_run_ctrl.sv
// rtl/qtree_run_ctrl.sv - kernel run controller (collect roots, issue tokens, await result); QTREE_RUN_CYCLES_EN adds run_cycles
module qtree_run_ctrl
    import qtree_ctrl_package::*;
#(
    parameter int NUM_ARGS = DEF_NUM_ARGS,
    parameter int PTR_W    = DEF_PTR_W,
    parameter int RES_W    = DEF_RES_W,
    parameter int TMO_W    = DEF_TMO_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [PTR_W:0]                 root_d,
    output logic                           root_r,
    output logic [NUM_ARGS-1:0][PTR_W:0]   arg_d,
    input  logic [NUM_ARGS-1:0]            arg_r,
    output logic                           go_d,
    input  logic                           go_r,
    input  logic [RES_W:0]                 res_d,
    output logic                           res_r,
    output logic [RES_W-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic [TMO_W-1:0]               tmo_limit,
    output logic                           busy,
    output logic                           err_tmo
`ifdef QTREE_RUN_CYCLES_EN
    ,
    output logic [31:0]                    run_cycles
`endif
);

    localparam int IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

    run_state_t                  state;
    logic [IDX_W-1:0]            idx;
    logic [NUM_ARGS-1:0][PTR_W:0] slot;
    logic [TMO_W-1:0]            timer;
    logic [TMO_W-1:0]            timer_inc;
    logic                        last_root;
    logic                        tmo_hit;
    logic [NUM_ARGS:0]           tok_pend;
    logic [NUM_ARGS:0]           tok_rdy;
    logic                        all_acc;

    // Argument tokens occupy the low positions, Go is the top token
    assign tok_rdy   = {go_r, arg_r};
    // A token that already dropped has been accepted; one with ready high is accepted this cycle
    assign all_acc   = &(~tok_pend | tok_rdy);
    assign last_root = (state == ST_COLLECT) && root_d[0] && (idx == IDX_W'(NUM_ARGS - 1));
    assign timer_inc = (&timer) ? timer : timer + 1'b1;
    assign tmo_hit   = (tmo_limit != '0) && (timer_inc >= tmo_limit);

    for (genvar g = 0; g <= NUM_ARGS; g++) begin : g_tok
        tok_issue u_tok (
            .clk     (clk),
            .reset   (reset),
            .load    (last_root),
            .ready   (tok_rdy[g]),
            .pending (tok_pend[g])
        );
    end

    // Argument bus carries the stored root only while its token is pending
    always_comb begin
        arg_d = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            arg_d[i] = tok_pend[i] ? slot[i] : '0;
        end
    end

    assign go_d      = tok_pend[NUM_ARGS];
    assign root_r    = (state == ST_COLLECT);
    assign res_r     = (state == ST_WAIT_RES);
    assign out_valid = (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);

    // Run sequencing: collect roots, wait out token acceptance, then result or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            slot     <= '0;
            timer    <= '0;
            out_data <= '0;
            err_tmo  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        state   <= ST_COLLECT;
                        idx     <= '0;
                        err_tmo <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (root_d[0]) begin
                        slot[idx] <= root_d;
                        if (last_root) begin
                            state <= ST_ISSUE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (all_acc) begin
                        state <= ST_WAIT_RES;
                        timer <= '0;
                    end
                end
                ST_WAIT_RES: begin
                    timer <= timer_inc;
                    // A result in the timeout cycle still completes the run
                    if (res_d[0]) begin
                        out_data <= res_d[RES_W:1];
                        state    <= ST_DRAIN;
                    end else if (tmo_hit) begin
                        state   <= ST_ERROR;
                        err_tmo <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef QTREE_RUN_CYCLES_EN
    logic [31:0] run_cnt;
    logic [31:0] run_inc;

    assign run_inc = (&run_cnt) ? run_cnt : run_cnt + 1'b1;

    // Count busy cycles of the current run and publish the total when DRAIN is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt    <= '0;
            run_cycles <= '0;
        end else begin
            if ((state == ST_IDLE || state == ST_ERROR) && start) begin
                run_cnt <= '0;
            end else if (state == ST_COLLECT || state == ST_ISSUE || state == ST_WAIT_RES) begin
                run_cnt <= run_inc;
            end
            if (state == ST_WAIT_RES && res_d[0]) begin
                run_cycles <= run_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qtree_run_ctrl.sv
// tb/tb_qtree_run_ctrl.sv - self-checking bench for qtree_run_ctrl
module tb_qtree_run_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [16:0]       root_d = '0;
    logic              root_r;
    logic [1:0][16:0]  arg_d;
    logic [1:0]        arg_r = '0;
    logic              go_d;
    logic              go_r = 1'b0;
    logic [32:0]       res_d = '0;
    logic              res_r;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       tmo_limit = '0;
    logic              busy;
    logic              err_tmo;
`ifdef QTREE_RUN_CYCLES_EN
    logic [31:0]       run_cycles;
`endif

    int total = 0;
    int bad   = 0;

    qtree_run_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .root_d    (root_d),
        .root_r    (root_r),
        .arg_d     (arg_d),
        .arg_r     (arg_r),
        .go_d      (go_d),
        .go_r      (go_r),
        .res_d     (res_d),
        .res_r     (res_r),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tmo_limit (tmo_limit),
        .busy      (busy),
        .err_tmo   (err_tmo)
`ifdef QTREE_RUN_CYCLES_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One run from IDLE/ERROR. Token i is held not-ready for d_i ISSUE cycles; the result
    // arrives in WAIT_RES cycle rwait. The run times out exactly when lim != 0 and rwait >= lim,
    // spending lim cycles in WAIT_RES; otherwise the result completes it.
    task automatic do_run(input logic [15:0] r0, input logic [15:0] r1,
                          input int d0, input int d1, input int dg,
                          input int rwait, input int lim, input logic [31:0] rv,
                          input int hold, input int gap, input bit poke);
        int  dmax;
        int  nw;
        bit  tmo;
        dmax = d0;
        if (d1 > dmax) dmax = d1;
        if (dg > dmax) dmax = dg;
        tmo  = (lim != 0) && (rwait >= lim);
        nw   = tmo ? lim : rwait + 1;
        tmo_limit = 16'(lim);

        start = 1'b1;
        step;
        start = 1'b0;
        chk("collect_root_r", root_r, 1);
        chk("collect_busy", busy, 1);
        chk("collect_err_clear", err_tmo, 0);

        root_d = {r0, 1'b1};
        step;
        for (int g = 0; g < gap; g++) begin
            root_d = {16'($urandom), 1'b0};
            chk("gap_root_r", root_r, 1);
            chk("gap_no_go", go_d, 0);
            step;
        end
        root_d = {r1, 1'b1};
        step;
        root_d = '0;

        for (int k = 0; k <= dmax; k++) begin
            chk("issue_arg0", arg_d[0], (k <= d0) ? {r0, 1'b1} : 17'h0);
            chk("issue_arg1", arg_d[1], (k <= d1) ? {r1, 1'b1} : 17'h0);
            chk("issue_go", go_d, (k <= dg) ? 1 : 0);
            chk("issue_root_r", root_r, 0);
            chk("issue_res_r", res_r, 0);
            arg_r[0] = (k >= d0);
            arg_r[1] = (k >= d1);
            go_r     = (k >= dg);
            step;
        end
        arg_r = '0;
        go_r  = 1'b0;

        for (int k = 0; k < nw; k++) begin
            chk("wait_res_r", res_r, 1);
            chk("wait_tokens", {arg_d, go_d}, 0);
            chk("wait_err", err_tmo, 0);
            res_d = (!tmo && k == rwait) ? {rv, 1'b1} : {rv, 1'b0};
            step;
        end
        res_d = '0;

        if (tmo) begin
            chk("err_tmo_set", err_tmo, 1);
            chk("err_busy", busy, 1);
            chk("err_res_r", res_r, 0);
            chk("err_no_valid", out_valid, 0);
            res_d = {rv, 1'b1};
            step;
            res_d = '0;
            chk("err_hold", err_tmo, 1);
            chk("err_stray_dropped", out_valid, 0);
        end else begin
            for (int h = 0; h < hold; h++) begin
                chk("drain_valid", out_valid, 1);
                chk("drain_data", out_data, rv);
                chk("drain_res_r", res_r, 0);
                start = poke && (h == hold / 2);
                step;
                start = 1'b0;
            end
            chk("drain_valid_final", out_valid, 1);
            chk("drain_data_final", out_data, rv);
            out_ready = 1'b1;
            step;
            out_ready = 1'b0;
            chk("idle_busy", busy, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_data_kept", out_data, rv);
            res_d = {~rv, 1'b1};
            step;
            res_d = '0;
            chk("stray_res_r", res_r, 0);
            chk("stray_dropped", out_data, rv);
            chk("stray_idle", busy, 0);
        end
    endtask

    initial begin
        step;
        step;
        chk("rst_root_r", root_r, 0);
        chk("rst_arg_d", arg_d, 0);
        chk("rst_go_d", go_d, 0);
        chk("rst_res_r", res_r, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_tmo", err_tmo, 0);
        reset = 1'b0;
        step;
        chk("post_rst_idle", busy, 0);

        // Nominal: all readies immediately, single-cycle ISSUE
        do_run(16'h0011, 16'h0022, 0, 0, 0, 2, 0, 32'h2A, 0, 0, 1'b0);
        // Staggered readies: arg 0 late by 3, Go late by 5
        do_run(16'h1234, 16'h4321, 3, 0, 5, 1, 0, 32'hCAFE_0001, 1, 1, 1'b0);
        // Timeout after 10 WAIT_RES cycles
        do_run(16'h0A0A, 16'h0B0B, 0, 1, 0, 100, 10, 32'h0, 0, 0, 1'b0);
        // Result in the timeout cycle wins; restart from ERROR clears err_tmo
        do_run(16'h0C0C, 16'h0D0D, 0, 0, 0, 9, 10, 32'h5A5A_A5A5, 0, 0, 1'b0);
        // Backpressure for 7 cycles with an ignored second start
        do_run(16'h7777, 16'h8888, 1, 2, 0, 3, 0, 32'h1357_9BDF, 7, 0, 1'b1);

        // Reset during ISSUE abandons the run
        tmo_limit = '0;
        start = 1'b1;
        step;
        start = 1'b0;
        root_d = {16'h00AA, 1'b1};
        step;
        root_d = {16'h00BB, 1'b1};
        step;
        root_d = '0;
        chk("pre_rst_go", go_d, 1);
        chk("pre_rst_arg1", arg_d[1], {16'h00BB, 1'b1});
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("rst_issue_tokens", {arg_d, go_d}, 0);
        chk("rst_issue_idle", busy, 0);
        step;
        chk("rst_issue_no_reissue", {arg_d, go_d}, 0);
        chk("rst_issue_still_idle", busy, 0);
        do_run(16'h0101, 16'h0202, 0, 2, 1, 4, 0, 32'hDEAD_BEEF, 2, 0, 1'b0);

        // Randomized runs
        for (int n = 0; n < 16; n++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            do_run(16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 14)), lim, 32'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
